e_74ls148_latched: RTL and testbench

Registered 8-to-3 priority encoder with 74LS148-style active-low pins (EI_N/EO_N/GS_N, inverted code), the encoding counterpart of the lab's 74LS138 decoder. Falling request lines are captured into a pending register. The block presents the highest-priority pending code, holds it stable until the consumer pulses ACK, then clears that bit. It sits between raw request/key lines and a downstream decoder or controller, and cascades through EI_N/EO_N like the TTL part.

---
 rtl/e_74ls148_latched.sv | 77 +++++++
 tb/tb_e_74ls148_latched.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/e_74ls148_latched.sv
// Registered 8-to-3 priority encoder with 74LS148-style active-low pins.
// Falling requests are held in a pending register and presented one code at a time until ACK clears them.
module e_74ls148_latched #(
  parameter bit LATCH = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ei_n,
  input  logic [7:0] i_n,
  input  logic       ack,
  output logic [2:0] a_n,
  output logic       gs_n,
  output logic       eo_n,
  output logic [7:0] pend
);

  typedef enum logic {IDLE, VALID} state_t;

  state_t     state;
  logic [7:0] s1, s2;
  logic       ei_q;
  logic [2:0] code;
  logic [2:0] top_idx;
  logic [7:0] rise;
  logic [7:0] clr;

  assign rise = s1 & ~s2;

  // Ascending scan: the last set bit found is the highest priority one.
  always_comb begin
    top_idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (pend[k]) top_idx = 3'(k);
    end
  end

  // An abort (ei_q high) takes precedence over ACK, so nothing is cleared then.
  always_comb begin
    clr = 8'h00;
    if (state == VALID && !ei_q && ack) clr[code] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 8'h00;
      s2    <= 8'h00;
      ei_q  <= 1'b1;
      pend  <= 8'h00;
      state <= IDLE;
      code  <= 3'd0;
    end else begin
      s1   <= ~i_n;
      s2   <= s1;
      ei_q <= ei_n;
      // Set wins over clear when a fresh edge lands on the acknowledged bit.
      pend <= LATCH ? ((pend & ~clr) | rise) : s1;
      case (state)
        IDLE: begin
          if (!ei_q && pend != 8'h00) begin
            code  <= top_idx;
            state <= VALID;
          end
        end
        VALID: begin
          if (ei_q)     state <= IDLE;
          else if (ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign gs_n = (state != VALID);
  assign a_n  = (state == VALID) ? ~code : 3'b111;
  assign eo_n = !(state == IDLE && pend == 8'h00 && !ei_q);

endmodule

// File: tb/tb_e_74ls148_latched.sv
// Bench for e_74ls148_latched: vector tables for latched and level-mode instances, checked through an expected-result queue.
module tb_e_74ls148_latched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ei_n = 1'b0;
  logic [7:0] i_n = 8'hFF;
  logic       ack = 1'b0;

  logic [2:0] a_n0, a_n1;
  logic       gs_n0, gs_n1, eo_n0, eo_n1;
  logic [7:0] pend0, pend1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic       sel;
    logic [7:0] i_n;
    logic       ei_n;
    logic       ack;
    logic [2:0] a_n;
    logic       gs_n;
    logic       eo_n;
    logic [7:0] pend;
  } vec_t;

  typedef struct {
    logic       sel;
    logic [2:0] a_n;
    logic       gs_n;
    logic       eo_n;
    logic [7:0] pend;
  } exp_t;

  vec_t tab[$];
  exp_t sb[$];
  int   row = 0;

  e_74ls148_latched #(.LATCH(1'b1)) dut_lat (
    .clk(clk), .rst_n(rst_n), .ei_n(ei_n), .i_n(i_n), .ack(ack),
    .a_n(a_n0), .gs_n(gs_n0), .eo_n(eo_n0), .pend(pend0)
  );

  e_74ls148_latched #(.LATCH(1'b0)) dut_lvl (
    .clk(clk), .rst_n(rst_n), .ei_n(ei_n), .i_n(i_n), .ack(ack),
    .a_n(a_n1), .gs_n(gs_n1), .eo_n(eo_n1), .pend(pend1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic sel, input logic [7:0] in, input logic ei, input logic ak,
                              input logic [2:0] a, input logic gs, input logic eo, input logic [7:0] p);
    vec_t v;
    v.sel = sel; v.i_n = in; v.ei_n = ei; v.ack = ak;
    v.a_n = a; v.gs_n = gs; v.eo_n = eo; v.pend = p;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h want %0h", name, idx, act, req);
    end
  endtask

  task automatic chk_outs(input string tag, input int idx, input exp_t e);
    if (e.sel) begin
      chk({tag, ".a_n"},  idx, {5'd0, a_n1},  {5'd0, e.a_n});
      chk({tag, ".gs_n"}, idx, {7'd0, gs_n1}, {7'd0, e.gs_n});
      chk({tag, ".eo_n"}, idx, {7'd0, eo_n1}, {7'd0, e.eo_n});
      chk({tag, ".pend"}, idx, pend1, e.pend);
    end else begin
      chk({tag, ".a_n"},  idx, {5'd0, a_n0},  {5'd0, e.a_n});
      chk({tag, ".gs_n"}, idx, {7'd0, gs_n0}, {7'd0, e.gs_n});
      chk({tag, ".eo_n"}, idx, {7'd0, eo_n0}, {7'd0, e.eo_n});
      chk({tag, ".pend"}, idx, pend0, e.pend);
    end
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    i_n  = v.i_n;
    ei_n = v.ei_n;
    ack  = v.ack;
    e.sel = v.sel; e.a_n = v.a_n; e.gs_n = v.gs_n; e.eo_n = v.eo_n; e.pend = v.pend;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard[%0d]: got empty queue want entry", row);
    end else begin
      e = sb.pop_front();
      chk_outs("row", row, e);
    end
    row++;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) step(tab[r]);
  endtask

  // Assert reset away from a clock edge, check both instances at once, release mid-cycle.
  task automatic do_reset();
    exp_t e;
    rst_n = 1'b0;
    #1;
    e.a_n = 3'b111; e.gs_n = 1'b1; e.eo_n = 1'b1; e.pend = 8'h00;
    e.sel = 1'b0; chk_outs("rst_lat", row, e);
    e.sel = 1'b1; chk_outs("rst_lvl", row, e);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int a_lo, a_hi, l_lo, l_hi, r_lo, r_hi;

    // Latched instance: single request, priority, no preemption, collision, abort.
    a_lo = tab.size();
    tab.push_back(mk(0, 8'hFF, 0, 0, 3'd7, 1, 0, 8'h00));
    tab.push_back(mk(0, 8'hDF, 0, 0, 3'd7, 1, 0, 8'h00));
    tab.push_back(mk(0, 8'hFF, 0, 0, 3'd7, 1, 1, 8'h20));
    tab.push_back(mk(0, 8'hFF, 0, 0, 3'd2, 0, 1, 8'h20));
    tab.push_back(mk(0, 8'hFF, 0, 0, 3'd2, 0, 1, 8'h20));
    tab.push_back(mk(0, 8'hFF, 0, 1, 3'd7, 1, 0, 8'h00));
    tab.push_back(mk(0, 8'hFF, 0, 1, 3'd7, 1, 0, 8'h00));
    tab.push_back(mk(0, 8'hBB, 0, 0, 3'd7, 1, 0, 8'h00));
    tab.push_back(mk(0, 8'hBB, 0, 0, 3'd7, 1, 1, 8'h44));
    tab.push_back(mk(0, 8'hBB, 0, 0, 3'd1, 0, 1, 8'h44));
    tab.push_back(mk(0, 8'hBB, 0, 1, 3'd7, 1, 1, 8'h04));
    tab.push_back(mk(0, 8'hBB, 0, 0, 3'd5, 0, 1, 8'h04));
    tab.push_back(mk(0, 8'hFF, 0, 1, 3'd7, 1, 0, 8'h00));
    tab.push_back(mk(0, 8'hFF, 0, 0, 3'd7, 1, 0, 8'h00));
    tab.push_back(mk(0, 8'hF7, 0, 0, 3'd7, 1, 0, 8'h00));
    tab.push_back(mk(0, 8'hF7, 0, 0, 3'd7, 1, 1, 8'h08));
    tab.push_back(mk(0, 8'hF7, 0, 0, 3'd4, 0, 1, 8'h08));
    tab.push_back(mk(0, 8'h77, 0, 0, 3'd4, 0, 1, 8'h08));
    tab.push_back(mk(0, 8'h77, 0, 0, 3'd4, 0, 1, 8'h88));
    tab.push_back(mk(0, 8'h77, 0, 0, 3'd4, 0, 1, 8'h88));
    tab.push_back(mk(0, 8'h77, 0, 1, 3'd7, 1, 1, 8'h80));
    tab.push_back(mk(0, 8'h77, 0, 0, 3'd0, 0, 1, 8'h80));
    tab.push_back(mk(0, 8'hFF, 0, 1, 3'd7, 1, 0, 8'h00));
    tab.push_back(mk(0, 8'hFF, 0, 0, 3'd7, 1, 0, 8'h00));
    tab.push_back(mk(0, 8'hF7, 0, 0, 3'd7, 1, 0, 8'h00));
    tab.push_back(mk(0, 8'hFF, 0, 0, 3'd7, 1, 1, 8'h08));
    tab.push_back(mk(0, 8'hFF, 0, 0, 3'd4, 0, 1, 8'h08));
    tab.push_back(mk(0, 8'hF7, 0, 0, 3'd4, 0, 1, 8'h08));
    tab.push_back(mk(0, 8'hF7, 0, 1, 3'd7, 1, 1, 8'h08));
    tab.push_back(mk(0, 8'hFF, 0, 0, 3'd4, 0, 1, 8'h08));
    tab.push_back(mk(0, 8'hFF, 1, 0, 3'd4, 0, 1, 8'h08));
    tab.push_back(mk(0, 8'hFF, 1, 0, 3'd7, 1, 1, 8'h08));
    tab.push_back(mk(0, 8'hFF, 1, 1, 3'd7, 1, 1, 8'h08));
    tab.push_back(mk(0, 8'hFF, 0, 0, 3'd7, 1, 1, 8'h08));
    tab.push_back(mk(0, 8'hFF, 0, 0, 3'd4, 0, 1, 8'h08));
    tab.push_back(mk(0, 8'hFF, 0, 1, 3'd7, 1, 0, 8'h00));
    tab.push_back(mk(0, 8'hFF, 0, 0, 3'd7, 1, 0, 8'h00));
    tab.push_back(mk(0, 8'hFF, 1, 0, 3'd7, 1, 1, 8'h00));
    tab.push_back(mk(0, 8'hFF, 0, 0, 3'd7, 1, 0, 8'h00));
    a_hi = tab.size() - 1;

    // Level-mode instance: held request re-presented after ACK, one-cycle pulse.
    l_lo = tab.size();
    tab.push_back(mk(1, 8'hFF, 0, 0, 3'd7, 1, 0, 8'h00));
    tab.push_back(mk(1, 8'hFD, 0, 0, 3'd7, 1, 0, 8'h00));
    tab.push_back(mk(1, 8'hFD, 0, 0, 3'd7, 1, 1, 8'h02));
    tab.push_back(mk(1, 8'hFD, 0, 0, 3'd6, 0, 1, 8'h02));
    tab.push_back(mk(1, 8'hFD, 0, 1, 3'd7, 1, 1, 8'h02));
    tab.push_back(mk(1, 8'hFD, 0, 0, 3'd6, 0, 1, 8'h02));
    tab.push_back(mk(1, 8'hFF, 0, 0, 3'd6, 0, 1, 8'h02));
    tab.push_back(mk(1, 8'hFF, 0, 0, 3'd6, 0, 1, 8'h00));
    tab.push_back(mk(1, 8'hFF, 0, 1, 3'd7, 1, 0, 8'h00));
    tab.push_back(mk(1, 8'hEF, 0, 0, 3'd7, 1, 0, 8'h00));
    tab.push_back(mk(1, 8'hFF, 0, 0, 3'd7, 1, 1, 8'h10));
    tab.push_back(mk(1, 8'hFF, 0, 0, 3'd3, 0, 1, 8'h00));
    tab.push_back(mk(1, 8'hFF, 0, 1, 3'd7, 1, 0, 8'h00));
    l_hi = tab.size() - 1;

    // Request held low across reset release is captured as a new edge.
    r_lo = tab.size();
    tab.push_back(mk(0, 8'hBF, 0, 0, 3'd7, 1, 0, 8'h00));
    tab.push_back(mk(0, 8'hBF, 0, 0, 3'd7, 1, 1, 8'h40));
    tab.push_back(mk(0, 8'hBF, 0, 0, 3'd1, 0, 1, 8'h40));
    tab.push_back(mk(0, 8'hBF, 0, 1, 3'd7, 1, 0, 8'h00));
    r_hi = tab.size() - 1;

    #3;
    do_reset();
    run_rows(a_lo, a_hi);

    i_n = 8'hFF; ei_n = 1'b0; ack = 1'b0;
    do_reset();
    run_rows(l_lo, l_hi);

    i_n = 8'hBF; ei_n = 1'b0; ack = 1'b0;
    do_reset();
    run_rows(r_lo, r_hi - 1);
    // Reset lands while the latched instance is VALID.
    do_reset();
    run_rows(r_lo, r_hi);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left: got %0d entries want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
